// File: rtl/rope_controller.sv
// Rope shot controller: launches on a fire-key rise and grows upward once per
// frame until a ball hit or the ceiling, then waits out a frame cooldown.
// Also draws the rope through a one-cycle registered pixel test and exports
// the rope geometry to the collision logic.
module rope_controller #(
    parameter int unsigned ROPE_WIDTH = 4,
    parameter int unsigned X_OFFSET   = 14,
    parameter int unsigned FLOOR_Y    = 440,
    parameter int unsigned CEILING_Y  = 20,
    parameter int unsigned SPEED      = 4,
    parameter int unsigned COOLDOWN   = 8,
    parameter logic [7:0]  ROPE_COLOR = 8'hFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        fireKey,
    input  logic [10:0] playerX,
    input  logic        ropeHit,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        ropeDrawingRequest,
    output logic [7:0]  ropeRGB,
    output logic        ropeActive,
    output logic [10:0] ropeX,
    output logic [10:0] ropeTopY
);

    localparam int unsigned CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXTEND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [10:0]       r_rope_x;
    logic [10:0]       w_rope_x_next;
    logic [10:0]       r_top_y;
    logic [10:0]       w_top_y_next;
    logic [CD_W-1:0]   r_cooldown;
    logic [CD_W-1:0]   w_cooldown_next;
    logic              r_fire_d;
    logic              r_draw;
    logic [7:0]        r_rgb;
    logic              w_fire_rise;
    logic              w_active;
    logic              w_hit_pix;
    logic [11:0]       w_x_hi;

    assign w_fire_rise = fireKey & ~r_fire_d;

    // State and shot datapath registers; reset aborts any shot in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rope_x   <= 11'd0;
            r_top_y    <= 11'(FLOOR_Y);
            r_cooldown <= '0;
            r_fire_d   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rope_x   <= w_rope_x_next;
            r_top_y    <= w_top_y_next;
            r_cooldown <= w_cooldown_next;
            r_fire_d   <= fireKey;
        end
    end

    // Next state: hit beats frame growth in EXTEND; cooldown counts frames in DONE
    always_comb begin
        w_state_next    = r_state;
        w_rope_x_next   = r_rope_x;
        w_top_y_next    = r_top_y;
        w_cooldown_next = r_cooldown;
        case (r_state)
            S_IDLE: begin
                if (w_fire_rise) begin
                    w_state_next  = S_EXTEND;
                    w_rope_x_next = playerX + 11'(X_OFFSET);
                    w_top_y_next  = 11'(FLOOR_Y);
                end
            end
            S_EXTEND: begin
                if (ropeHit) begin
                    w_state_next    = S_DONE;
                    w_cooldown_next = CD_W'(COOLDOWN);
                end else if (startOfFrame) begin
                    if (r_top_y <= 11'(CEILING_Y + SPEED)) begin
                        w_top_y_next    = 11'(CEILING_Y);
                        w_state_next    = S_DONE;
                        w_cooldown_next = CD_W'(COOLDOWN);
                    end else begin
                        w_top_y_next = r_top_y - 11'(SPEED);
                    end
                end
            end
            S_DONE: begin
                // A zero cooldown also leaves on the first frame
                if (startOfFrame) begin
                    if (r_cooldown <= CD_W'(1)) begin
                        w_state_next    = S_IDLE;
                        w_cooldown_next = '0;
                    end else begin
                        w_cooldown_next = r_cooldown - CD_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state: active flag and the per-pixel rope test
    always_comb begin
        w_active  = (r_state == S_EXTEND);
        // 12-bit upper bound so a rope near X=2047 does not wrap
        w_x_hi    = 12'(r_rope_x) + 12'(ROPE_WIDTH);
        w_hit_pix = w_active
                  & (pixelX >= r_rope_x)
                  & ({1'b0, pixelX} < w_x_hi)
                  & (pixelY >= r_top_y)
                  & (pixelY < 11'(FLOOR_Y));
    end

    // Registered drawing request and colour, one cycle behind the scan
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw <= 1'b0;
            r_rgb  <= 8'h00;
        end else begin
            r_draw <= w_hit_pix;
            r_rgb  <= w_hit_pix ? ROPE_COLOR : 8'h00;
        end
    end

    assign ropeDrawingRequest = r_draw;
    assign ropeRGB            = r_rgb;
    assign ropeActive         = w_active;
    assign ropeX              = r_rope_x;
    assign ropeTopY           = r_top_y;

endmodule

// File: tb/tb_rope_controller.sv
// Bench for rope_controller: pixel table checked through a scoreboard queue,
// plus hand-written launch, ceiling, hit, cooldown and reset sequences.
module tb_rope_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        startOfFrame;
    logic        fireKey;
    logic [10:0] playerX;
    logic        ropeHit;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        ropeDrawingRequest;
    logic [7:0]  ropeRGB;
    logic        ropeActive;
    logic [10:0] ropeX;
    logic [10:0] ropeTopY;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic        req;
    } vec_t;

    typedef struct {
        logic       req;
        logic [7:0] rgb;
        string      name;
    } exp_t;

    vec_t vecs [8];
    exp_t sbq [$];

    rope_controller dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .fireKey            (fireKey),
        .playerX            (playerX),
        .ropeHit            (ropeHit),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .ropeDrawingRequest (ropeDrawingRequest),
        .ropeRGB            (ropeRGB),
        .ropeActive         (ropeActive),
        .ropeX              (ropeX),
        .ropeTopY           (ropeTopY)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic launch(input logic [10:0] px);
        playerX = px;
        fireKey = 1'b0;
        tick();
        fireKey = 1'b1;
        tick();
    endtask

    // Present one pixel, push its expectation, pop and compare a cycle later
    task automatic pix(input string name, input logic [10:0] px, input logic [10:0] py,
                       input logic req);
        exp_t e;
        pixelX = px;
        pixelY = py;
        sbq.push_back('{req: req, rgb: (req ? 8'hFC : 8'h00), name: name});
        tick();
        if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, expected one entry", name);
        end else begin
            e = sbq.pop_front();
            check({e.name, "_req"}, 32'(ropeDrawingRequest), 32'(e.req));
            check({e.name, "_rgb"}, 32'(ropeRGB), 32'(e.rgb));
        end
        pixelX = 11'd0;
        pixelY = 11'd0;
    endtask

    initial begin
        vecs[0] = '{px: 11'd114, py: 11'd436, req: 1'b1};
        vecs[1] = '{px: 11'd117, py: 11'd436, req: 1'b1};
        vecs[2] = '{px: 11'd118, py: 11'd436, req: 1'b0};
        vecs[3] = '{px: 11'd113, py: 11'd436, req: 1'b0};
        vecs[4] = '{px: 11'd114, py: 11'd435, req: 1'b0};
        vecs[5] = '{px: 11'd114, py: 11'd440, req: 1'b0};
        vecs[6] = '{px: 11'd114, py: 11'd439, req: 1'b1};
        vecs[7] = '{px: 11'd116, py: 11'd438, req: 1'b1};

        reset        = 1'b1;
        startOfFrame = 1'b0;
        fireKey      = 1'b0;
        playerX      = 11'd0;
        ropeHit      = 1'b0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;

        // Reset and idle frames with the key released
        do_reset();
        for (int f = 0; f < 3; f++) frame();
        check("idle_req", 32'(ropeDrawingRequest), 32'd0);
        check("idle_active", 32'(ropeActive), 32'd0);
        check("idle_topy", 32'(ropeTopY), 32'd440);
        check("idle_rgb", 32'(ropeRGB), 32'd0);
        check("idle_x", 32'(ropeX), 32'd0);
        ropeHit = 1'b1;
        tick();
        ropeHit = 1'b0;
        check("idle_hit_ignored", 32'(ropeActive), 32'd0);

        // Launch, one frame of growth, then the pixel table
        launch(11'd100);
        check("launch_active", 32'(ropeActive), 32'd1);
        check("launch_topy", 32'(ropeTopY), 32'd440);
        fireKey = 1'b0;
        frame();
        check("grow_x", 32'(ropeX), 32'd114);
        check("grow_topy", 32'(ropeTopY), 32'd436);
        for (int i = 0; i < 8; i++) begin
            pix($sformatf("pix%0d", i), vecs[i].px, vecs[i].py, vecs[i].req);
        end

        // Ceiling termination with the key held throughout
        do_reset();
        launch(11'd100);
        for (int f = 1; f <= 104; f++) frame();
        check("ceil104_topy", 32'(ropeTopY), 32'd24);
        check("ceil104_active", 32'(ropeActive), 32'd1);
        frame();
        check("ceil105_topy", 32'(ropeTopY), 32'd20);
        check("ceil105_active", 32'(ropeActive), 32'd0);
        pix("ceil_nodraw", 11'd115, 11'd100, 1'b0);
        for (int f = 0; f < 10; f++) frame();
        check("held_no_relaunch_active", 32'(ropeActive), 32'd0);
        check("held_no_relaunch_topy", 32'(ropeTopY), 32'd20);
        fireKey = 1'b0;

        // Hit coinciding with a frame pulse freezes the top row
        do_reset();
        launch(11'd100);
        fireKey = 1'b0;
        for (int f = 0; f < 10; f++) frame();
        check("pre_hit_topy", 32'(ropeTopY), 32'd400);
        ropeHit      = 1'b1;
        startOfFrame = 1'b1;
        tick();
        ropeHit      = 1'b0;
        startOfFrame = 1'b0;
        check("hit_active", 32'(ropeActive), 32'd0);
        check("hit_topy", 32'(ropeTopY), 32'd400);
        pix("hit_nodraw", 11'd115, 11'd420, 1'b0);

        // Cooldown: rises before frames 1..7 are discarded, IDLE on frame 8
        for (int f = 1; f <= 7; f++) begin
            fireKey = 1'b0;
            tick();
            fireKey = 1'b1;
            tick();
            check($sformatf("cd_rise%0d_active", f), 32'(ropeActive), 32'd0);
            frame();
        end
        fireKey = 1'b0;
        tick();
        check("cd7_topy", 32'(ropeTopY), 32'd400);
        frame();
        check("cd8_active", 32'(ropeActive), 32'd0);
        fireKey = 1'b1;
        tick();
        check("relaunch_active", 32'(ropeActive), 32'd1);
        check("relaunch_topy", 32'(ropeTopY), 32'd440);
        fireKey = 1'b0;

        // Asynchronous reset in the middle of a shot
        do_reset();
        launch(11'd200);
        fireKey = 1'b0;
        for (int f = 0; f < 35; f++) frame();
        check("mid_topy", 32'(ropeTopY), 32'd300);
        pixelX = 11'd215;
        pixelY = 11'd350;
        tick();
        check("mid_req", 32'(ropeDrawingRequest), 32'd1);
        check("mid_rgb", 32'(ropeRGB), 32'hFC);
        #2;
        reset = 1'b1;
        #1;
        check("async_req", 32'(ropeDrawingRequest), 32'd0);
        check("async_rgb", 32'(ropeRGB), 32'd0);
        check("async_active", 32'(ropeActive), 32'd0);
        check("async_topy", 32'(ropeTopY), 32'd440);
        check("async_x", 32'(ropeX), 32'd0);
        tick();
        reset  = 1'b0;
        pixelX = 11'd0;
        pixelY = 11'd0;
        tick();
        check("post_reset_active", 32'(ropeActive), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
